// File: rtl/gate_selftest_ctrl.sv
// Exhaustive self-test sequencer for a small combinational gate: walks every input vector,
// holds it for a settle time, samples the gate output and scores it against a truth table.
module gate_selftest_ctrl #(
    parameter int                     N_INPUTS      = 2,
    parameter int                     SETTLE_CYCLES = 2,
    parameter logic [2**N_INPUTS-1:0] EXPECTED      = 4'b0111
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     gate_out,
    output logic [N_INPUTS-1:0]      stim,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [2**N_INPUTS-1:0]   result,
    output logic [N_INPUTS:0]        fail_count,
    output logic [N_INPUTS-1:0]      first_fail
);

    localparam int NUM_VEC = 2**N_INPUTS;
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [N_INPUTS-1:0] VEC_LAST    = N_INPUTS'(NUM_VEC - 1);
    localparam logic [N_INPUTS-1:0] VEC_ONE     = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   FC_ONE      = (N_INPUTS + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [N_INPUTS-1:0]    vec_q, vec_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_INPUTS-1:0]    stim_q, stim_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [NUM_VEC-1:0]     result_q, result_d;
    logic [N_INPUTS:0]      fail_count_q, fail_count_d;
    logic [N_INPUTS-1:0]    first_fail_q, first_fail_d;

    // Every output is registered, so each one is computed here from the next state.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        stim_d       = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_d       = pass_q;
        result_d     = result_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d      = ST_SETTLE;
                    vec_d        = '0;
                    cnt_d        = '0;
                    result_d     = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    stim_d       = '0;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                    stim_d = vec_q;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    // Abort wins over the sample: the partial score stays as it was.
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    result_d[vec_q] = gate_out;
                    if (gate_out != EXPECTED[vec_q]) begin
                        fail_count_d = fail_count_q + FC_ONE;
                        if (fail_count_q == '0) begin
                            first_fail_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        state_d = ST_SETTLE;
                        vec_d   = vec_q + VEC_ONE;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        stim_d  = vec_q + VEC_ONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            result_q     <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            result_q     <= result_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign result     = result_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Randomized self-checking bench for gate_selftest_ctrl: a behavioural gate with a chosen truth
// table, glitches outside sample cycles, and a truth-table scoring model for expected results.
module tb_gate_selftest_ctrl;

    localparam int N       = 2;
    localparam int SETTLE  = 2;
    localparam int NV      = 2**N;
    localparam int PER_VEC = SETTLE + 1;
    localparam int RUN_LEN = NV * PER_VEC;
    localparam logic [NV-1:0] EXP_TT = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          glitch = 1'b0;
    logic          gate_out;
    logic [NV-1:0] gate_tt = EXP_TT;
    logic [N-1:0]  stim;
    logic          busy, done, pass;
    logic [NV-1:0] result;
    logic [N:0]    fail_count;
    logic [N-1:0]  first_fail;

    int n_checks = 0;
    int n_fail   = 0;
    int run_id   = 0;

    always #5 clk = ~clk;

    // Gate under test; the glitch term is only ever nonzero outside sample cycles.
    assign gate_out = gate_tt[stim] ^ glitch;

    gate_selftest_ctrl #(
        .N_INPUTS      (N),
        .SETTLE_CYCLES (SETTLE),
        .EXPECTED      (EXP_TT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .gate_out   (gate_out),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .result     (result),
        .fail_count (fail_count),
        .first_fail (first_fail)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (run %0d, t=%0t)", tag, got, exp, run_id, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Score the first n_done vectors of a truth table against the expected one.
    task automatic model(input logic [NV-1:0] tt, input int n_done,
                         output logic [NV-1:0] m_res, output int m_fc, output int m_ff);
        m_res = '0;
        m_fc  = 0;
        m_ff  = 0;
        for (int v = 0; v < n_done; v++) begin
            m_res[v] = tt[v];
            if (tt[v] != EXP_TT[v]) begin
                if (m_fc == 0) m_ff = v;
                m_fc++;
            end
        end
    endtask

    task automatic check_no_done_window(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < RUN_LEN + 2; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check_val(tag, seen, 0);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    // One run: abort_at / rst_at > 0 cut the run in that cycle after start acceptance.
    task automatic do_run(input logic [NV-1:0] tt, input int abort_at, input bit poke_start,
                          input int rst_at);
        logic [NV-1:0] m_res;
        int            m_fc, m_ff, stop, n_sampled;
        string         mode;
        bit            m_pass;

        run_id++;
        gate_tt = tt;
        stop = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at : RUN_LEN);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= stop; c++) begin
            check_val("busy_run", busy, 1);
            check_val("done_early", done, 0);
            check_val("stim_seq", stim, (c - 1) / PER_VEC);
            if (c == 1) begin
                check_val("clr_result", result, 0);
                check_val("clr_fail_count", fail_count, 0);
                check_val("clr_pass", pass, 0);
            end
            glitch = (c % PER_VEC != 0) ? 1'($urandom) : 1'b0;
            if (poke_start && c == 4) start = 1'b1;
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst_n = 1'b0;
            tick();
            start  = 1'b0;
            abort  = 1'b0;
            rst_n  = 1'b1;
            glitch = 1'b0;
        end

        if (rst_at > 0) begin
            mode = "reset";
            check_val("rst_busy", busy, 0);
            check_val("rst_done", done, 0);
            check_val("rst_stim", stim, 0);
            check_val("rst_pass", pass, 0);
            check_val("rst_result", result, 0);
            check_val("rst_fail_count", fail_count, 0);
            check_val("rst_first_fail", first_fail, 0);
            check_no_done_window("rst_no_done");
        end else if (abort_at > 0) begin
            mode = "abort";
            n_sampled = (abort_at - 1) / PER_VEC;
            model(tt, n_sampled, m_res, m_fc, m_ff);
            check_val("abort_busy", busy, 0);
            check_val("abort_stim", stim, 0);
            check_val("abort_done", done, 0);
            check_val("abort_pass", pass, 0);
            check_val("abort_result", result, m_res);
            check_val("abort_fail_count", fail_count, m_fc);
            check_val("abort_first_fail", first_fail, m_ff);
            check_no_done_window("abort_no_done");
            check_val("abort_result_held", result, m_res);
        end else begin
            mode = poke_start ? "normal+poke" : "normal";
            model(tt, NV, m_res, m_fc, m_ff);
            m_pass = (m_fc == 0);
            check_val("done_pulse", done, 1);
            check_val("done_busy", busy, 0);
            check_val("done_stim", stim, 0);
            check_val("result", result, m_res);
            check_val("fail_count", fail_count, m_fc);
            check_val("first_fail", first_fail, m_ff);
            check_val("pass", pass, m_pass);
            if (poke_start) start = 1'b1;
            tick();
            start = 1'b0;
            check_val("done_single", done, 0);
            check_val("idle_busy", busy, 0);
            tick();
            tick();
            check_val("pass_held", pass, m_pass);
            check_val("result_held", result, m_res);
        end
        $display("run %0d mode=%s tt=%b result=%b fail_count=%0d first_fail=%0d pass=%0b",
                 run_id, mode, tt, result, fail_count, first_fail, pass);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NV-1:0] tt;
        int            mode;

        rst_n = 1'b0;
        tick();
        tick();
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_stim", stim, 0);
        check_val("reset_pass", pass, 0);
        check_val("reset_result", result, 0);
        check_val("reset_fail_count", fail_count, 0);
        check_val("reset_first_fail", first_fail, 0);
        rst_n = 1'b1;
        tick();

        do_run(4'b0111, 0, 1'b0, 0);   // healthy NAND
        do_run(4'b1111, 0, 1'b0, 0);   // stuck-at-1
        do_run(4'b0000, 0, 1'b0, 0);   // stuck-at-0
        do_run(EXP_TT,  0, 1'b1, 0);   // start pokes mid-run and in DONE
        do_run(EXP_TT,  5, 1'b0, 0);   // abort mid-run
        do_run(EXP_TT,  0, 1'b0, 0);   // clean run after abort
        do_run(4'b1010, 0, 1'b0, 7);   // reset mid-run

        // start and abort together in IDLE must not launch a run
        run_id++;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_busy", busy, 0);
        check_no_done_window("start_abort_no_done");
        $display("run %0d mode=start+abort busy=%0b", run_id, busy);

        for (int r = 0; r < 30; r++) begin
            tt   = NV'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                2:       do_run(tt, $urandom_range(1, RUN_LEN), 1'($urandom), 0);
                3:       do_run(tt, 0, 1'($urandom), $urandom_range(1, RUN_LEN));
                default: do_run(tt, 0, 1'($urandom), 0);
            endcase
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
